// File: rtl/textmap_ctrl.sv
// Text-map clear/scroll engine sharing one memory port with a CPU that always wins arbitration.
// Define TEXTMAP_CTRL_SCROLL_EN to build the scroll engine (SCR_RD/SCR_WR/FILL); otherwise only clear and CPU access exist.
module textmap_ctrl #(
    parameter int TEXT_COLS = 84,
    parameter int TEXT_ROWS = 24,
    parameter int ADDRW     = 11,
    parameter int WORDW     = 16
) (
    input  logic             clk_sys,
    input  logic             rst_sys_n,
    input  logic             cmd_clear,
    input  logic             cmd_scroll,
    input  logic [WORDW-1:0] fill_word,
    output logic             busy,
    output logic             done,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [ADDRW-1:0] cpu_addr,
    input  logic [WORDW-1:0] cpu_wdata,
    output logic             cpu_ack,
    output logic             cpu_rvalid,
    output logic [WORDW-1:0] cpu_rdata,
    output logic [ADDRW-1:0] mem_addr,
    output logic             mem_we,
    output logic [WORDW-1:0] mem_wdata,
    input  logic [WORDW-1:0] mem_rdata
);

    // state  | meaning
    // IDLE   | waiting for cmd_clear / cmd_scroll
    // CLEAR  | writing fill_word to every cell
    // SCR_RD | reading cell a+TEXT_COLS
    // SCR_WR | writing the captured word to cell a
    // FILL   | writing fill_word across the last row
`ifdef TEXTMAP_CTRL_SCROLL_EN
    typedef enum logic [2:0] {IDLE, CLEAR, SCR_RD, SCR_WR, FILL} state_t;
`else
    typedef enum logic [2:0] {IDLE, CLEAR} state_t;
`endif

    localparam int TOTAL = TEXT_COLS * TEXT_ROWS;
    localparam logic [ADDRW-1:0] CLR_LAST = ADDRW'(TOTAL - 1);

    state_t           state, state_nxt;
    logic [ADDRW-1:0] cnt, cnt_nxt;
    logic             done_nxt;
    logic             go;
    logic [ADDRW-1:0] eng_addr;
    logic             eng_we;
    logic [WORDW-1:0] eng_wdata;
    logic [WORDW-1:0] rdata_hold;

`ifdef TEXTMAP_CTRL_SCROLL_EN
    localparam logic [ADDRW-1:0] ROW_STEP  = ADDRW'(TEXT_COLS);
    localparam logic [ADDRW-1:0] COPY_LAST = ADDRW'(TEXT_COLS * (TEXT_ROWS - 1) - 1);
    localparam logic [ADDRW-1:0] LAST_ROW  = ADDRW'(TEXT_COLS * (TEXT_ROWS - 1));
    localparam logic [ADDRW-1:0] FILL_LAST = ADDRW'(TEXT_COLS - 1);

    logic             rd_pend;
    logic [WORDW-1:0] cap_data;
`else
    logic unused_scroll;
    assign unused_scroll = cmd_scroll;
`endif

    assign go   = ~cpu_req;
    assign busy = (state != IDLE);

    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n) begin
            state      <= IDLE;
            cnt        <= '0;
            done       <= 1'b0;
            cpu_rvalid <= 1'b0;
            rdata_hold <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            done       <= done_nxt;
            cpu_rvalid <= cpu_req & ~cpu_we;
            if (cpu_rvalid)
                rdata_hold <= mem_rdata;
        end
    end

`ifdef TEXTMAP_CTRL_SCROLL_EN
    // The word read in SCR_RD arrives one cycle later; capture it then even if the CPU holds the port.
    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n) begin
            rd_pend  <= 1'b0;
            cap_data <= '0;
        end else begin
            rd_pend <= (state == SCR_RD) && go;
            if (rd_pend)
                cap_data <= mem_rdata;
        end
    end
`endif

    assign cpu_rdata = cpu_rvalid ? mem_rdata : rdata_hold;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        eng_addr  = '0;
        eng_we    = 1'b0;
        eng_wdata = '0;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (cmd_clear)
                    state_nxt = CLEAR;
`ifdef TEXTMAP_CTRL_SCROLL_EN
                else if (cmd_scroll)
                    state_nxt = SCR_RD;
`endif
            end
            CLEAR: begin
                eng_addr  = cnt;
                eng_we    = 1'b1;
                eng_wdata = fill_word;
                if (go) begin
                    if (cnt == CLR_LAST) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
`ifdef TEXTMAP_CTRL_SCROLL_EN
            SCR_RD: begin
                eng_addr = cnt + ROW_STEP;
                if (go)
                    state_nxt = SCR_WR;
            end
            SCR_WR: begin
                eng_addr  = cnt;
                eng_we    = 1'b1;
                eng_wdata = rd_pend ? mem_rdata : cap_data;
                if (go) begin
                    if (cnt == COPY_LAST) begin
                        state_nxt = FILL;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = SCR_RD;
                        cnt_nxt   = cnt + 1'b1;
                    end
                end
            end
            FILL: begin
                eng_addr  = LAST_ROW + cnt;
                eng_we    = 1'b1;
                eng_wdata = fill_word;
                if (go) begin
                    if (cnt == FILL_LAST) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cpu_ack   = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (rst_sys_n) begin
            if (cpu_req) begin
                cpu_ack   = 1'b1;
                mem_addr  = cpu_addr;
                mem_we    = cpu_we;
                mem_wdata = cpu_wdata;
            end else begin
                mem_addr  = eng_addr;
                mem_we    = eng_we;
                mem_wdata = eng_wdata;
            end
        end
    end

endmodule

// File: tb/tb_textmap_ctrl.sv
// Bench for textmap_ctrl: memory model on the mem port, queue-of-operations reference model, per-cycle compare.
// Follows TEXTMAP_CTRL_SCROLL_EN the same way the design does.
module tb_textmap_ctrl;

    localparam int C     = 84;
    localparam int R     = 24;
    localparam int TOTAL = C * R;
`ifdef TEXTMAP_CTRL_SCROLL_EN
    localparam bit SCR = 1'b1;
`else
    localparam bit SCR = 1'b0;
`endif

    logic        clk_sys = 1'b0;
    logic        rst_sys_n = 1'b0;
    logic        cmd_clear = 1'b0, cmd_scroll = 1'b0;
    logic [15:0] fill_word = '0;
    logic        busy, done;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [10:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_ack, cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic [10:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    textmap_ctrl dut (
        .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
        .cmd_clear(cmd_clear), .cmd_scroll(cmd_scroll), .fill_word(fill_word),
        .busy(busy), .done(done),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk_sys = ~clk_sys;

    logic [15:0] mem [0:2047];
    always @(posedge clk_sys) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int n_acks   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference model: the engine is a queue of pending memory operations, one popped per free cycle.
    typedef enum int {K_FILL, K_RD, K_COPY} kind_t;
    typedef struct { kind_t kind; int addr; } op_t;
    op_t         opq[$];
    op_t         op;
    logic [15:0] mm [0:2047];
    logic [15:0] m_copy;
    logic        m_done = 1'b0, m_rv = 1'b0;
    logic [15:0] m_rdata = '0;
    logic        nd, nrv, was_idle;

    always @(negedge clk_sys) begin
        chk("busy", busy, (opq.size() != 0) ? 1 : 0);
        chk("done", done, m_done);
        chk("cpu_rvalid", cpu_rvalid, m_rv);
        chk("cpu_rdata", cpu_rdata, m_rdata);
        if (cpu_ack === 1'b1) n_acks++;
        if (!rst_sys_n) begin
            chk("rst_ack", cpu_ack, 0);
            chk("rst_we", mem_we, 0);
            chk("rst_addr", mem_addr, 0);
            chk("rst_wdata", mem_wdata, 0);
        end else if (cpu_req) begin
            chk("cpu_ack", cpu_ack, 1);
            chk("cpu_mem_addr", mem_addr, cpu_addr);
            chk("cpu_mem_we", mem_we, cpu_we);
            if (cpu_we) chk("cpu_mem_wdata", mem_wdata, cpu_wdata);
        end else begin
            chk("no_ack", cpu_ack, 0);
            if (opq.size() == 0) chk("idle_we", mem_we, 0);
            else begin
                chk("eng_addr", mem_addr, opq[0].addr);
                chk("eng_we", mem_we, (opq[0].kind == K_RD) ? 0 : 1);
                if (opq[0].kind == K_FILL) chk("eng_fill", mem_wdata, fill_word);
                if (opq[0].kind == K_COPY) chk("eng_copy", mem_wdata, m_copy);
            end
        end

        if (!rst_sys_n) begin
            opq.delete();
            m_done  = 1'b0;
            m_rv    = 1'b0;
            m_rdata = '0;
        end else begin
            was_idle = (opq.size() == 0);
            nd = 1'b0;
            nrv = 1'b0;
            if (cpu_req) begin
                if (cpu_we) mm[cpu_addr] = cpu_wdata;
                else begin
                    nrv = 1'b1;
                    m_rdata = mm[cpu_addr];
                end
            end else if (!was_idle) begin
                op = opq.pop_front();
                case (op.kind)
                    K_FILL: mm[op.addr] = fill_word;
                    K_RD:   m_copy = mm[op.addr];
                    default: mm[op.addr] = m_copy;
                endcase
                if (opq.size() == 0) nd = 1'b1;
            end
            if (was_idle) begin
                if (cmd_clear) begin
                    for (int i = 0; i < TOTAL; i++) opq.push_back('{K_FILL, i});
                end else if (cmd_scroll && SCR) begin
                    for (int a = 0; a < C * (R - 1); a++) begin
                        opq.push_back('{K_RD, a + C});
                        opq.push_back('{K_COPY, a});
                    end
                    for (int k = 0; k < C; k++) opq.push_back('{K_FILL, C * (R - 1) + k});
                end
            end
            m_done = nd;
            m_rv   = nrv;
        end
    end

    task automatic step();
        @(posedge clk_sys); #1;
    endtask

    task automatic issue(input bit clr, input bit scr, output int t_start);
        cmd_clear = clr; cmd_scroll = scr;
        step();
        t_start = cyc;
        cmd_clear = 1'b0; cmd_scroll = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int t_done);
        t_done = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_sys);
            if (done === 1'b1) begin t_done = cyc; break; end
        end
        step();
    endtask

    task automatic check_image(input string nm);
        int bad, first;
        bad = 0; first = -1;
        for (int i = 0; i < TOTAL; i++)
            if (mem[i] !== mm[i]) begin bad++; if (first < 0) first = i; end
        chk(nm, bad, 0);
        if (bad != 0) $display("  first differing word %0d: memory %0h model %0h", first, mem[first], mm[first]);
    endtask

    int t0, t1, a0;

    initial begin
        repeat (3) step();
        rst_sys_n = 1'b1;
        @(negedge clk_sys);
        chk("reset_busy", busy, 0);
        chk("reset_rvalid", cpu_rvalid, 0);
        chk("reset_rdata", cpu_rdata, 0);
        step();

        fill_word = 16'h0720;
        issue(1, 0, t0);
        wait_done(3000, t1);
        chk("clear_latency", t1 - t0, 2016);
        chk("clear_word0", mem[0], 16'h0720);
        chk("clear_word2015", mem[2015], 16'h0720);
        check_image("clear_image");

        cpu_req = 1; cpu_we = 1; cpu_addr = 11'd5; cpu_wdata = 16'h1234;
        step();
        cpu_we = 0;
        @(negedge clk_sys);
        chk("rd_ack", cpu_ack, 1);
        step();
        cpu_req = 0;
        @(negedge clk_sys);
        chk("rd_rvalid", cpu_rvalid, 1);
        chk("rd_data", cpu_rdata, 16'h1234);
        step();
        step();
        chk("rd_hold", cpu_rdata, 16'h1234);

        cpu_req = 1; cpu_we = 1;
        for (int r = 0; r < R; r++)
            for (int k = 0; k < C; k++) begin
                cpu_addr = 11'(r * C + k); cpu_wdata = 16'(r);
                step();
            end
        cpu_req = 0; cpu_we = 0;
        issue(0, 1, t0);
`ifdef TEXTMAP_CTRL_SCROLL_EN
        wait_done(5000, t1);
        chk("scroll_latency", t1 - t0, 3948);
        chk("scroll_row0", mem[0], 16'd1);
        chk("scroll_row22", mem[22 * C + 83], 16'd23);
        chk("scroll_row23", mem[23 * C], 16'h0720);
`else
        @(negedge clk_sys);
        chk("scroll_ignored", busy, 0);
        step();
`endif
        check_image("scroll_image");

`ifdef TEXTMAP_CTRL_SCROLL_EN
        issue(0, 1, t0);
        repeat (500) step();
        a0 = n_acks;
        cpu_req = 1; cpu_we = 0;
        for (int i = 0; i < 10; i++) begin
            cpu_addr = 11'($urandom_range(TOTAL - 1));
            step();
        end
        cpu_req = 0;
        wait_done(5000, t1);
        chk("burst_latency", t1 - t0, 3958);
        chk("burst_acks", n_acks - a0, 10);
        check_image("burst_image");
`endif

        issue(1, 1, t0);
        repeat (50) step();
        cmd_scroll = 1; step(); cmd_scroll = 0;
        wait_done(3000, t1);
        chk("both_latency", t1 - t0, 2016);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_sys);
            chk("both_idle", busy, 0);
        end
        step();
        check_image("both_image");

        fill_word = 16'hBEEF;
        issue(!SCR, SCR, t0);
        repeat (100) step();
        rst_sys_n = 0;
        step();
        @(negedge clk_sys);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        rst_sys_n = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_sys);
            chk("abort_no_done", done, 0);
        end
        step();
        check_image("abort_image");

        for (int i = 0; i < 4000; i++) begin
            cpu_req    = ($urandom_range(3) == 0);
            cpu_we     = $urandom_range(1);
            cpu_addr   = 11'($urandom_range(TOTAL - 1));
            cpu_wdata  = 16'($urandom);
            fill_word  = 16'($urandom);
            cmd_clear  = ($urandom_range(399) == 0);
            cmd_scroll = ($urandom_range(199) == 0);
            step();
        end
        cpu_req = 0; cmd_clear = 0; cmd_scroll = 0;
        for (int i = 0; i < 12000; i++) begin
            @(negedge clk_sys);
            if (busy !== 1'b1) break;
        end
        chk("drain", busy, 0);
        step();
        check_image("random_image");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
